// File: rtl/approx_seq_divider.sv
// approx_seq_divider: iterative restoring divider, one quotient row per clock.
// The low APPROX_ROWS rows may use the approximate subtractor cell
// (q bit from the window MSB, remainder = W & d) when approx_en is set at
// acceptance. Results are bit-identical to the combinational array divider
// with the same row configuration.
module approx_seq_divider #(
    parameter int unsigned N_W         = 16,
    parameter int unsigned D_W         = 8,
    parameter int unsigned APPROX_ROWS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_W-1:0]     n,
    input  logic [D_W-1:0]     d,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_W-D_W-1:0] q,
    output logic [D_W-1:0]     r,
    output logic               dz,
    output logic               ovf
);

    localparam int unsigned Q_W  = N_W - D_W;
    localparam int unsigned K_W  = (Q_W > 1) ? $clog2(Q_W) : 1;
    localparam int unsigned NI_W = $clog2(N_W);

    // Per-row approximate-cell enable mask: bit k set when k < APPROX_ROWS
    localparam logic [Q_W:0]   APX_LIM  = (Q_W+1)'(1) << APPROX_ROWS;
    localparam logic [Q_W:0]   APX_M1   = APX_LIM - (Q_W+1)'(1);
    localparam logic [Q_W-1:0] APX_MASK = APX_M1[Q_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched operation context
    logic [N_W-1:0] r_n;
    logic [D_W-1:0] r_d;
    logic           r_approx;
    logic           r_dz_p;
    logic           r_ovf_p;

    // Row iteration state: top bit, window, row index, quotient accumulator
    logic           r_t;
    logic [D_W-1:0] r_w;
    logic [K_W-1:0] r_k;
    logic [Q_W-1:0] r_qacc;

    // Registered outputs
    logic           r_in_ready;
    logic           r_out_valid;
    logic [Q_W-1:0] r_q;
    logic [D_W-1:0] r_r;
    logic           r_dz;
    logic           r_ovf;

    // Next values
    logic [N_W-1:0] w_n_nxt;
    logic [D_W-1:0] w_d_nxt;
    logic           w_approx_nxt;
    logic           w_dz_p_nxt;
    logic           w_ovf_p_nxt;
    logic           w_t_nxt;
    logic [D_W-1:0] w_w_nxt;
    logic [K_W-1:0] w_k_nxt;
    logic [Q_W-1:0] w_qacc_nxt;
    logic           w_in_ready_nxt;
    logic           w_out_valid_nxt;
    logic [Q_W-1:0] w_q_nxt;
    logic [D_W-1:0] w_r_nxt;
    logic           w_dz_nxt;
    logic           w_ovf_nxt;

    // Row datapath
    logic            w_accept;
    logic [D_W:0]    w_sub;
    logic            w_borrow;
    logic [D_W-1:0]  w_diff;
    logic            w_row_apx;
    logic            w_qbit;
    logic [D_W-1:0]  w_rem;
    logic [NI_W-1:0] w_nidx;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign r         = r_r;
    assign dz        = r_dz;
    assign ovf       = r_ovf;

    assign w_accept = (r_state == S_IDLE) && in_valid && r_in_ready;

    // One quotient row: exact restoring cell or approximate cell
    always_comb begin
        w_sub     = {1'b0, r_w} - {1'b0, r_d};
        w_borrow  = w_sub[D_W];
        w_diff    = w_sub[D_W-1:0];
        w_row_apx = r_approx & APX_MASK[r_k];
        w_qbit    = 1'b0;
        w_rem     = r_w;
        if (w_row_apx) begin
            w_qbit = r_t | r_w[D_W-1];
            w_rem  = w_qbit ? (r_w & r_d) : r_w;
        end else begin
            w_qbit = r_t | ~w_borrow;
            w_rem  = w_qbit ? w_diff : r_w;
        end
        w_nidx = NI_W'(r_k) - NI_W'(1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_CALC;
            S_CALC: if (r_k == '0) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        w_n_nxt         = r_n;
        w_d_nxt         = r_d;
        w_approx_nxt    = r_approx;
        w_dz_p_nxt      = r_dz_p;
        w_ovf_p_nxt     = r_ovf_p;
        w_t_nxt         = r_t;
        w_w_nxt         = r_w;
        w_k_nxt         = r_k;
        w_qacc_nxt      = r_qacc;
        w_out_valid_nxt = r_out_valid;
        w_q_nxt         = r_q;
        w_r_nxt         = r_r;
        w_dz_nxt        = r_dz;
        w_ovf_nxt       = r_ovf;
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_n_nxt      = n;
                    w_d_nxt      = d;
                    w_approx_nxt = approx_en;
                    w_dz_p_nxt   = (d == '0);
                    w_ovf_p_nxt  = (n[N_W-1:Q_W] >= d);
                    w_t_nxt      = n[N_W-1];
                    w_w_nxt      = n[N_W-2 -: D_W];
                    w_k_nxt      = K_W'(Q_W - 1);
                    w_qacc_nxt   = '0;
                end
            end
            S_CALC: begin
                w_qacc_nxt[r_k] = w_qbit;
                w_t_nxt         = w_rem[D_W-1];
                if (r_k == '0) begin
                    w_q_nxt         = w_qacc_nxt;
                    w_r_nxt         = w_rem;
                    w_dz_nxt        = r_dz_p;
                    w_ovf_nxt       = r_ovf_p;
                    w_out_valid_nxt = 1'b1;
                end else begin
                    w_w_nxt = {w_rem[D_W-2:0], r_n[w_nidx]};
                    w_k_nxt = r_k - K_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) w_out_valid_nxt = 1'b0;
            end
            default: begin
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n         <= '0;
            r_d         <= '0;
            r_approx    <= 1'b0;
            r_dz_p      <= 1'b0;
            r_ovf_p     <= 1'b0;
            r_t         <= 1'b0;
            r_w         <= '0;
            r_k         <= '0;
            r_qacc      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_n         <= w_n_nxt;
            r_d         <= w_d_nxt;
            r_approx    <= w_approx_nxt;
            r_dz_p      <= w_dz_p_nxt;
            r_ovf_p     <= w_ovf_p_nxt;
            r_t         <= w_t_nxt;
            r_w         <= w_w_nxt;
            r_k         <= w_k_nxt;
            r_qacc      <= w_qacc_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_q         <= w_q_nxt;
            r_r         <= w_r_nxt;
            r_dz        <= w_dz_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_approx_seq_divider.sv
// Directed bench for approx_seq_divider (16/8, 4 approximate rows) plus an
// exact 32/16 instance checked against integer division.
module tb_approx_seq_divider;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        tb_in_valid  = 1'b0;
    logic        tb_in_ready;
    logic [15:0] tb_n         = '0;
    logic [7:0]  tb_d         = '0;
    logic        tb_ae        = 1'b0;
    logic        tb_out_valid;
    logic        tb_out_ready = 1'b1;
    logic [7:0]  tb_q;
    logic [7:0]  tb_r;
    logic        tb_dz;
    logic        tb_ovf;

    logic        b_in_valid  = 1'b0;
    logic        b_in_ready;
    logic [31:0] b_n         = '0;
    logic [15:0] b_d         = '0;
    logic        b_ae        = 1'b0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [15:0] b_q;
    logic [15:0] b_r;
    logic        b_dz;
    logic        b_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    approx_seq_divider #(.N_W(16), .D_W(8), .APPROX_ROWS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(tb_in_valid), .in_ready(tb_in_ready),
        .n(tb_n), .d(tb_d), .approx_en(tb_ae),
        .out_valid(tb_out_valid), .out_ready(tb_out_ready),
        .q(tb_q), .r(tb_r), .dz(tb_dz), .ovf(tb_ovf)
    );

    approx_seq_divider #(.N_W(32), .D_W(16), .APPROX_ROWS(0)) dut_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .n(b_n), .d(b_d), .approx_en(b_ae),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .q(b_q), .r(b_r), .dz(b_dz), .ovf(b_ovf)
    );

    // Present one operand to the 16/8 instance; returns the acceptance time.
    // Operands and approx_en are scrambled right after acceptance.
    task automatic start_op(input logic [15:0] vn, input logic [7:0] vd,
                            input logic ae, output longint t_acc);
        int g = 0;
        @(negedge clk);
        while (!tb_in_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (!tb_in_ready) begin
            n_vec++; n_err++;
            $display("FAIL start_timeout in_ready=%b required=1", tb_in_ready);
        end
        tb_n = vn; tb_d = vd; tb_ae = ae; tb_in_valid = 1'b1;
        @(posedge clk);
        t_acc = longint'($time);
        #1;
        tb_in_valid = 1'b0;
        tb_ae = ~ae;
        tb_n  = ~vn;
        tb_d  = ~vd;
    endtask

    // Count edges after acceptance until out_valid; -1 when the bound expires
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!tb_out_valid && lat < 40);
        if (!tb_out_valid) lat = -1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (tb_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", tb_in_ready); end
        n_vec++; if (tb_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", tb_out_valid); end
        n_vec++; if (tb_q !== 8'd0) begin n_err++; $display("FAIL rst_q got=%0d exp=0", tb_q); end
        n_vec++; if (tb_r !== 8'd0) begin n_err++; $display("FAIL rst_r got=%0d exp=0", tb_r); end
        n_vec++; if ({tb_dz, tb_ovf} !== 2'b00) begin n_err++; $display("FAIL rst_flags got=%b exp=00", {tb_dz, tb_ovf}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (tb_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready got=%b exp=1", tb_in_ready); end
        n_vec++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_wide_in_ready got=%b exp=1", b_in_ready); end
    endtask

    task automatic test_exact();
        longint t;
        int lat;
        start_op(16'd1000, 8'd7, 1'b0, t);
        wait_done(lat);
        n_vec++; if (lat != 8) begin n_err++; $display("FAIL exact_latency got=%0d exp=8", lat); end
        n_vec++; if (tb_q !== 8'd142) begin n_err++; $display("FAIL exact_q got=%0d exp=142", tb_q); end
        n_vec++; if (tb_r !== 8'd6) begin n_err++; $display("FAIL exact_r got=%0d exp=6", tb_r); end
        n_vec++; if ({tb_dz, tb_ovf} !== 2'b00) begin n_err++; $display("FAIL exact_flags got=%b exp=00", {tb_dz, tb_ovf}); end
    endtask

    task automatic test_approx_shallow();
        longint t;
        int lat;
        start_op(16'd1000, 8'd7, 1'b1, t);
        wait_done(lat);
        n_vec++; if (tb_q !== 8'd128) begin n_err++; $display("FAIL apx_shallow_q got=%0d exp=128", tb_q); end
        n_vec++; if (tb_r !== 8'd104) begin n_err++; $display("FAIL apx_shallow_r got=%0d exp=104", tb_r); end
    endtask

    task automatic test_approx_diff();
        longint t;
        int lat;
        start_op(16'h9600, 8'hC0, 1'b1, t);
        wait_done(lat);
        n_vec++; if (tb_q !== 8'hCE) begin n_err++; $display("FAIL apx_diff_q got=%0h exp=ce", tb_q); end
        n_vec++; if (tb_r !== 8'h00) begin n_err++; $display("FAIL apx_diff_r got=%0h exp=0", tb_r); end
        start_op(16'h9600, 8'hC0, 1'b0, t);
        wait_done(lat);
        n_vec++; if (tb_q !== 8'd200) begin n_err++; $display("FAIL exact_diff_q got=%0d exp=200", tb_q); end
        n_vec++; if (tb_r !== 8'd0) begin n_err++; $display("FAIL exact_diff_r got=%0d exp=0", tb_r); end
        n_vec++; if ({tb_dz, tb_ovf} !== 2'b00) begin n_err++; $display("FAIL exact_diff_flags got=%b exp=00", {tb_dz, tb_ovf}); end
    endtask

    task automatic test_div_zero();
        longint t;
        int lat;
        start_op(16'h1234, 8'h00, 1'b0, t);
        wait_done(lat);
        n_vec++; if (tb_q !== 8'hFF) begin n_err++; $display("FAIL dz_q got=%0h exp=ff", tb_q); end
        n_vec++; if (tb_r !== 8'h34) begin n_err++; $display("FAIL dz_r got=%0h exp=34", tb_r); end
        n_vec++; if (tb_dz !== 1'b1) begin n_err++; $display("FAIL dz_flag got=%b exp=1", tb_dz); end
        n_vec++; if (tb_ovf !== 1'b1) begin n_err++; $display("FAIL dz_ovf got=%b exp=1", tb_ovf); end
    endtask

    task automatic test_backpressure();
        longint t;
        int lat;
        start_op(16'h9600, 8'hC0, 1'b0, t);
        tb_out_ready = 1'b0;
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tb_in_valid = (i % 2 == 0);
            tb_n = 16'd49;
            tb_d = 8'd7;
            n_vec++; if (tb_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, tb_out_valid); end
            n_vec++; if ({tb_q, tb_r} !== {8'd200, 8'd0}) begin n_err++; $display("FAIL bp_hold[%0d] got q=%0d r=%0d exp q=200 r=0", i, tb_q, tb_r); end
            n_vec++; if (tb_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, tb_in_ready); end
        end
        @(negedge clk);
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (tb_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid got=%b exp=0", tb_out_valid); end
        n_vec++; if (tb_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got=%b exp=1", tb_in_ready); end
        start_op(16'd49, 8'd7, 1'b0, t);
        wait_done(lat);
        n_vec++; if (tb_q !== 8'd7) begin n_err++; $display("FAIL bp_next_q got=%0d exp=7", tb_q); end
        n_vec++; if (tb_r !== 8'd0) begin n_err++; $display("FAIL bp_next_r got=%0d exp=0", tb_r); end
    endtask

    task automatic test_back_to_back();
        longint t0, t1;
        int lat;
        start_op(16'd49, 8'd7, 1'b0, t0);
        wait_done(lat);
        n_vec++; if (tb_q !== 8'd7) begin n_err++; $display("FAIL b2b_q0 got=%0d exp=7", tb_q); end
        start_op(16'd1000, 8'd7, 1'b0, t1);
        n_vec++; if ((t1 - t0) != 100) begin n_err++; $display("FAIL b2b_period got=%0d exp=10 cycles", (t1 - t0) / 10); end
        wait_done(lat);
        n_vec++; if ({tb_q, tb_r} !== {8'd142, 8'd6}) begin n_err++; $display("FAIL b2b_res1 got q=%0d r=%0d exp q=142 r=6", tb_q, tb_r); end
    endtask

    task automatic test_reset_mid();
        longint t;
        int lat;
        start_op(16'd1000, 8'd7, 1'b0, t);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (tb_out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid got=%b exp=0", tb_out_valid); end
        n_vec++; if (tb_in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_in_ready got=%b exp=0", tb_in_ready); end
        n_vec++; if ({tb_q, tb_r} !== 16'd0) begin n_err++; $display("FAIL rmid_qr got q=%0d r=%0d exp 0 0", tb_q, tb_r); end
        n_vec++; if ({tb_dz, tb_ovf} !== 2'b00) begin n_err++; $display("FAIL rmid_flags got=%b exp=00", {tb_dz, tb_ovf}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (tb_in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_release_in_ready got=%b exp=1", tb_in_ready); end
        start_op(16'd1000, 8'd7, 1'b0, t);
        wait_done(lat);
        n_vec++; if (lat != 8) begin n_err++; $display("FAIL rmid_latency got=%0d exp=8", lat); end
        n_vec++; if ({tb_q, tb_r} !== {8'd142, 8'd6}) begin n_err++; $display("FAIL rmid_result got q=%0d r=%0d exp q=142 r=6", tb_q, tb_r); end
    endtask

    task automatic test_random_exact();
        logic [15:0] vd;
        logic [31:0] vn;
        logic [31:0] eq;
        logic [31:0] er;
        int          g;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            if (i == 0) begin
                vd = 16'd1; vn = 32'h0000_FFFF;
            end else if (i == 1) begin
                vd = 16'hFFFF; vn = 32'hFFFE_FFFF;
            end else begin
                vd = 16'($urandom_range(1, 65535));
                vn = {16'($urandom % {16'd0, vd}), 16'($urandom)};
            end
            eq = vn / {16'd0, vd};
            er = vn % {16'd0, vd};
            g = 0;
            @(negedge clk);
            while (!b_in_ready && g < 40) begin
                @(negedge clk);
                g++;
            end
            b_n = vn; b_d = vd; b_ae = 1'($urandom_range(0, 1)); b_in_valid = 1'b1;
            @(posedge clk);
            #1 b_in_valid = 1'b0;
            b_n = ~vn;
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!b_out_valid && lat < 60);
            n_vec++; if (lat != 16 || !b_out_valid) begin n_err++; $display("FAIL wide_latency[%0d] got=%0d valid=%b exp=16", i, lat, b_out_valid); end
            n_vec++; if (b_q !== eq[15:0]) begin n_err++; $display("FAIL wide_q[%0d] n=%0h d=%0h got=%0h exp=%0h", i, vn, vd, b_q, eq[15:0]); end
            n_vec++; if (b_r !== er[15:0]) begin n_err++; $display("FAIL wide_r[%0d] n=%0h d=%0h got=%0h exp=%0h", i, vn, vd, b_r, er[15:0]); end
            n_vec++; if ({b_dz, b_ovf} !== 2'b00) begin n_err++; $display("FAIL wide_flags[%0d] got=%b exp=00", i, {b_dz, b_ovf}); end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_approx_shallow();
        test_approx_diff();
        test_div_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random_exact();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
